// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA horizontal/vertical timing generator
//
// Owns free-running horizontal and vertical counters. It decodes the sync,
// back porch, visible and front porch regions from them and drives registered
// sync, visibility, coordinates and line/frame strobes to the pixel pipeline.
//
// Each axis runs in the order: sync [0, SYNC-1], back porch, visible, front porch.
// Every output is registered from the next-state counter values. As a result,
// hs/vs/video_on/x/y describe the same position as the counters on any given
// cycle, with no extra latency.
//
// Optional feature macro: VGA_FRAME_COUNT_EN (adds the 16-bit frame_count output).
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   pix_en       in   pixel-rate clock enable; counters advance only when high
//   hs           out  horizontal sync (active-low when HS_NEG=1)
//   vs           out  vertical sync (active-low when VS_NEG=1)
//   video_on     out  high while both axes are in their visible region
//   x            out  horizontal visible coordinate, 0 outside the visible span
//   y            out  vertical visible coordinate, 0 outside the visible span
//   line_start   out  one-clk pulse on the advance that wraps h_count to 0
//   frame_start  out  one-clk pulse on the advance that wraps both counters to 0
//   frame_count  out  (VGA_FRAME_COUNT_EN only) frames started since reset, wraps

module vga_timing_gen #(
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int CNT_W     = 10,
    parameter int HS_NEG    = 1,
    parameter int VS_NEG    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic             hs,
    output logic             vs,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
`ifdef VGA_FRAME_COUNT_EN
    output logic             frame_start,
    output logic [15:0]      frame_count
`else
    output logic             frame_start
`endif
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_VIS_START = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] V_VIS_START = CNT_W'(V_SYNC + V_BACK);

    // Exclusive end of the visible span. It is one bit wider so that a
    // zero-length front porch does not overflow when the span ends at the total.
    localparam logic [CNT_W:0]   H_VIS_END   = (CNT_W+1)'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [CNT_W:0]   V_VIS_END   = (CNT_W+1)'(V_SYNC + V_BACK + V_VISIBLE);

    localparam logic HS_ACT = (HS_NEG != 0) ? 1'b0 : 1'b1;
    localparam logic VS_ACT = (VS_NEG != 0) ? 1'b0 : 1'b1;

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_wrap;
    logic             v_wrap;
    logic             adv_line;
    logic             adv_frame;

    logic             h_vis_n;
    logic             v_vis_n;
    logic             hs_n;
    logic             vs_n;
    logic [CNT_W-1:0] x_n;
    logic [CNT_W-1:0] y_n;

    // Next counter position. While pix_en is low the next position equals the
    // current one, so the decoded outputs below hold without a separate enable.
    always_comb begin
        h_wrap    = (h_count == H_LAST);
        v_wrap    = (v_count == V_LAST);
        h_next    = h_count;
        v_next    = v_count;
        adv_line  = 1'b0;
        adv_frame = 1'b0;
        if (pix_en) begin
            if (h_wrap) begin
                h_next   = '0;
                adv_line = 1'b1;
                if (v_wrap) begin
                    v_next    = '0;
                    adv_frame = 1'b1;
                end else begin
                    v_next = v_count + CNT_W'(1);
                end
            end else begin
                h_next = h_count + CNT_W'(1);
            end
        end
    end

    // Region decode of the next position.
    always_comb begin
        h_vis_n = (h_next >= H_VIS_START) && ({1'b0, h_next} < H_VIS_END);
        v_vis_n = (v_next >= V_VIS_START) && ({1'b0, v_next} < V_VIS_END);
        hs_n    = (h_next < H_SYNC_END) ? HS_ACT : ~HS_ACT;
        vs_n    = (v_next < V_SYNC_END) ? VS_ACT : ~VS_ACT;
        x_n     = h_vis_n ? (h_next - H_VIS_START) : '0;
        y_n     = v_vis_n ? (v_next - V_VIS_START) : '0;
    end

    // Reset parks at position (0,0). That position lies inside both sync
    // regions, so both syncs come out of reset at their active level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count     <= '0;
            v_count     <= '0;
            hs          <= HS_ACT;
            vs          <= VS_ACT;
            video_on    <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_count     <= h_next;
            v_count     <= v_next;
            hs          <= hs_n;
            vs          <= vs_n;
            video_on    <= h_vis_n && v_vis_n;
            x           <= x_n;
            y           <= y_n;
            line_start  <= adv_line;
            frame_start <= adv_frame;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (adv_frame) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (default and small configs)

module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_d, pix_en_d, reset_s, pix_en_s;

    logic       d_hs, d_vs, d_vo, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_vo, s_ls, s_fs;
    logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    vga_timing_gen dut_d (
        .clk(clk), .reset(reset_d), .pix_en(pix_en_d),
        .hs(d_hs), .vs(d_vs), .video_on(d_vo), .x(d_x), .y(d_y),
        .line_start(d_ls),
`ifdef VGA_FRAME_COUNT_EN
        .frame_start(d_fs), .frame_count(d_fc)
`else
        .frame_start(d_fs)
`endif
    );

    vga_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_VISIBLE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_VISIBLE(4), .V_FRONT(1),
        .CNT_W(10), .HS_NEG(0), .VS_NEG(0)
    ) dut_s (
        .clk(clk), .reset(reset_s), .pix_en(pix_en_s),
        .hs(s_hs), .vs(s_vs), .video_on(s_vo), .x(s_x), .y(s_y),
        .line_start(s_ls),
`ifdef VGA_FRAME_COUNT_EN
        .frame_start(s_fs), .frame_count(s_fc)
`else
        .frame_start(s_fs)
`endif
    );

    typedef struct {
        logic hs;
        logic vs;
        logic vo;
        int   x;
        int   y;
        logic ls;
        logic fs;
        int   fc;
    } exp_t;

    exp_t q_d[$];
    exp_t q_s[$];

    int n_cmp  = 0;
    int n_fail = 0;

    int dh, dv;
    int sh, sv, sfc;
    int st, last_ls, last_fs;
    bit per_chk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference view of one position. hneg/vneg select active-low syncs.
    function automatic exp_t model(input int h, input int v,
                                   input int hsw, input int hb, input int hvis,
                                   input int vsw, input int vb, input int vvis,
                                   input bit hneg, input bit vneg,
                                   input bit ls, input bit fs, input int fc);
        exp_t e;
        bit hv, vv;
        hv   = (h >= hsw + hb) && (h < hsw + hb + hvis);
        vv   = (v >= vsw + vb) && (v < vsw + vb + vvis);
        e.hs = (h < hsw) ? !hneg : hneg;
        e.vs = (v < vsw) ? !vneg : vneg;
        e.vo = hv && vv;
        e.x  = hv ? h - (hsw + hb) : 0;
        e.y  = vv ? v - (vsw + vb) : 0;
        e.ls = ls;
        e.fs = fs;
        e.fc = fc;
        return e;
    endfunction

    task automatic s_step(input logic pen);
        exp_t e;
        bit ls, fs;
        ls = 0;
        fs = 0;
        if (pen) begin
            if (sh == 13) begin
                sh = 0;
                ls = 1;
                if (sv == 6) begin
                    sv = 0;
                    fs = 1;
                    sfc = (sfc + 1) % 65536;
                end else begin
                    sv++;
                end
            end else begin
                sh++;
            end
        end
        q_s.push_back(model(sh, sv, 2, 2, 8, 1, 1, 4, 0, 0, ls, fs, sfc));
        pix_en_s = pen;
        @(posedge clk);
        #1;
        st++;
        e = q_s.pop_front();
        chk("s_hs", s_hs, e.hs);
        chk("s_vs", s_vs, e.vs);
        chk("s_video_on", s_vo, e.vo);
        chk("s_x", s_x, e.x);
        chk("s_y", s_y, e.y);
        chk("s_line_start", s_ls, e.ls);
        chk("s_frame_start", s_fs, e.fs);
`ifdef VGA_FRAME_COUNT_EN
        chk("s_frame_count", s_fc, e.fc);
`endif
        if (per_chk && s_ls === 1'b1) begin
            if (last_ls >= 0) chk("ls_period", st - last_ls, 14);
            last_ls = st;
        end
        if (per_chk && s_fs === 1'b1) begin
            if (last_fs >= 0) chk("fs_period", st - last_fs, 98);
            last_fs = st;
        end
    endtask

    task automatic d_step(input bit cmp);
        exp_t e;
        bit ls, fs;
        ls = 0;
        fs = 0;
        if (dh == 799) begin
            dh = 0;
            ls = 1;
            if (dv == 524) begin
                dv = 0;
                fs = 1;
            end else begin
                dv++;
            end
        end else begin
            dh++;
        end
        if (cmp) q_d.push_back(model(dh, dv, 96, 48, 640, 2, 33, 480, 1, 1, ls, fs, 0));
        pix_en_d = 1'b1;
        @(posedge clk);
        #1;
        if (cmp) begin
            e = q_d.pop_front();
            chk("d_hs", d_hs, e.hs);
            chk("d_vs", d_vs, e.vs);
            chk("d_video_on", d_vo, e.vo);
            chk("d_x", d_x, e.x);
            chk("d_y", d_y, e.y);
            chk("d_line_start", d_ls, e.ls);
            chk("d_frame_start", d_fs, e.fs);
            if (dh == 144 && dv == 35) begin
                chk("first_vis_on", d_vo, 1);
                chk("first_vis_x", d_x, 0);
                chk("first_vis_y", d_y, 0);
            end
            if (dh == 783 && dv == 35) chk("last_vis_x", d_x, 639);
            if (dh == 784 && dv == 35) begin
                chk("front_porch_on", d_vo, 0);
                chk("front_porch_x", d_x, 0);
            end
        end
    endtask

    task automatic s_chk_reset(input string pfx);
        chk({pfx, "_hs"}, s_hs, 1);
        chk({pfx, "_vs"}, s_vs, 1);
        chk({pfx, "_video_on"}, s_vo, 0);
        chk({pfx, "_x"}, s_x, 0);
        chk({pfx, "_y"}, s_y, 0);
        chk({pfx, "_line_start"}, s_ls, 0);
        chk({pfx, "_frame_start"}, s_fs, 0);
`ifdef VGA_FRAME_COUNT_EN
        chk({pfx, "_frame_count"}, s_fc, 0);
`endif
    endtask

    initial begin
        reset_d  = 1'b1;
        reset_s  = 1'b1;
        pix_en_d = 1'b0;
        pix_en_s = 1'b1;
        st = 0; last_ls = -1; last_fs = -1; per_chk = 0;
        @(posedge clk);
        #1;

        chk("d_rst_hs", d_hs, 0);
        chk("d_rst_vs", d_vs, 0);
        chk("d_rst_video_on", d_vo, 0);
        chk("d_rst_x", d_x, 0);
        chk("d_rst_y", d_y, 0);
        chk("d_rst_line_start", d_ls, 0);
        chk("d_rst_frame_start", d_fs, 0);
        s_chk_reset("s_rst");

        reset_d = 1'b0;
        reset_s = 1'b0;
        pix_en_s = 1'b0;
        dh = 0; dv = 0;
        sh = 0; sv = 0; sfc = 0;

        // Default timing: first line, then fast-forward to the first visible line.
        for (int i = 0; i < 900; i++) d_step(1);
        for (int i = 0; i < 30000 && !(dv == 35 && dh == 139); i++) d_step(0);
        chk("d_reach_line35_x", d_x, 0);
        for (int i = 0; i < 660; i++) d_step(1);
        pix_en_d = 1'b0;

        // Small config, continuous pixel enable, three frames.
        per_chk = 1;
        for (int i = 0; i < 294; i++) s_step(1'b1);
        per_chk = 0;

        // Small config, pixel enable toggling.
        for (int i = 0; i < 196; i++) s_step((i % 2) == 0);

        // Small config, reset mid-frame at (9,3).
        for (int i = 0; i < 200 && !(sh == 9 && sv == 3); i++) s_step(1'b1);
        chk("mid_x", s_x, 5);
        chk("mid_y", s_y, 1);
        #2;
        reset_s = 1'b1;
        #1;
        s_chk_reset("s_async_rst");
        sh = 0; sv = 0; sfc = 0;
        pix_en_s = 1'b1;
        @(posedge clk);
        #1;
        s_chk_reset("s_rst_hold");
        reset_s = 1'b0;
        for (int i = 0; i < 120; i++) s_step(1'b1);

        chk("queues_empty", q_s.size() + q_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the single-threshold sync comparator.
- Owns free-running horizontal and vertical counters.
- Decodes sync, back porch, visible and front porch regions for both axes.
- Drives registered hs/vs/video_on and visible-area pixel coordinates, plus line/frame strobes, to the pixel-generation logic of the VGA pipeline.

Parameters:
H_SYNC, 96, horizontal sync width in pixels (region starts at h_count 0)
H_BACK, 48, horizontal back porch
H_VISIBLE, 640, horizontal visible pixels
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vertical sync width in lines (region starts at v_count 0)
V_BACK, 33, vertical back porch
V_VISIBLE, 480, vertical visible lines
V_FRONT, 10, vertical front porch
CNT_W, 10, width of counters and coordinates; must hold H/V totals minus 1
HS_NEG, 1, 1 = hs active-low, 0 = active-high
VS_NEG, 1, 1 = vs active-low, 0 = active-high

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
pix_en  input  1  pixel-rate clock enable; counters advance only when high
hs  output  1  horizontal sync, polarity per HS_NEG
vs  output  1  vertical sync, polarity per VS_NEG
video_on  output  1  high while both axes are in the visible region
x  output  CNT_W  h_count-(H_SYNC+H_BACK) when horizontally visible, else 0
y  output  CNT_W  v_count-(V_SYNC+V_BACK) when vertically visible, else 0
line_start  output  1  one-clk pulse when h_count wraps to 0
frame_start  output  1  one-clk pulse when both counters wrap to 0

Behaviour:
- H_TOTAL = H_SYNC+H_BACK+H_VISIBLE+H_FRONT; V_TOTAL likewise. Defaults: 800 x 525.
- Region order per axis: sync [0, SYNC-1], back porch, visible, front porch.
  - Default horizontal visible range: 144..783.
  - Default vertical visible range: 35..514.
- Counter advance, on a clk edge with pix_en=1:
  - h_count = h_count+1, or 0 when h_count = H_TOTAL-1.
  - When h_count wraps, v_count = v_count+1, or 0 when v_count = V_TOTAL-1.
  - pix_en=0: both counters and all level outputs hold.
- All outputs are registered and decoded from next-state counter values. On the edge where a counter changes, hs/vs/video_on/x/y take the values for the new position (zero added latency relative to the counters).
- Sync asserted (active level) when the axis count < SYNC width; otherwise inactive level.
- video_on = h_visible AND v_visible. x and y are independently gated by their own axis visibility.
- line_start:
  - High for exactly one clk after an advancing edge that wraps h_count to 0.
  - Low on every other clk, including held cycles with pix_en=0.
- frame_start: same rule, for the edge where both counters wrap to 0. On that edge line_start is also high.
- Reset (asynchronous, any time, including mid-line or mid-frame):
  - Counters go to 0.
  - hs = active level, vs = active level, video_on=0, x=0, y=0.
  - line_start=0, frame_start=0.
  - First advancing edge after reset release moves to h_count=1; no strobes are generated by reset itself.
- Arithmetic is unsigned CNT_W bits. Parameters violating the CNT_W capacity are illegal; no wrap protection is required.
- pix_en permanently high: one pixel per clk.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- When defined:
  - Adds output port frame_count (16 bits).
  - Reset value 0.
  - Increments on the same edge that raises frame_start; wraps 16'hFFFF -> 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, pix_en=1, reset pulse:
  - During reset, hs=0, vs=0, video_on=0, x=0, y=0.
  - After release, hs low for counts 0..95 and high at 96.
- Defaults, first visible line:
  - video_on rises exactly when (h,v) = (144,35), with x=0, y=0.
  - At (783,514): x=639, y=479.
  - At h=784: video_on=0 and x=0.
- Small config (H 2/2/8/2, V 1/1/4/1, HS_NEG=0, VS_NEG=0):
  - line_start pulses every 14 clks.
  - frame_start pulses every 98 clks, coinciding with line_start.
  - hs high for counts 0..1; vs high during line 0.
- Small config, pix_en toggling 1/0:
  - Counters advance every other clk.
  - line_start pulses last a single clk and do not stretch over held cycles.
- Small config, reset asserted mid-frame at (h,v) = (9,3):
  - Outputs immediately take their reset values.
  - Frame restarts from (0,0); no spurious frame_start pulse occurs.
- VGA_FRAME_COUNT_EN defined, small config, 3 frames:
  - frame_count reads 1, 2, 3 after each frame_start.
  - After a mid-run reset, frame_count = 0.
